dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer for the byte-addressed data memory of the pipelined CPU. It shares the single memory between the CPU MEM stage (port C) and the program-loader/debug port (port D). It drives the memory's address, data, load/store-size and read/write strobes, and returns registered read data and a one-cycle acknowledge to the winning requester. It also generates the CPU stall and flags out-of-range accesses without touching memory.

## Interface
- MEM_BYTES, 1024, memory size in bytes; legal byte addresses are 0..MEM_BYTES-1
- STARVE_LIMIT, 4, consecutive C grants while D waits before D is forced to win
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  one clock; reset is synchronous and active-low
- c_req, c_we  in  1 each  C request; C write (1) / read (0)
- c_addr, c_wdata  in  32 each  C byte address; C write data
- c_load  in  3  C load type: 000 lb, 001 lbu, 010 lh, 011 lhu, 100 lw
- c_store  in  2  C store size: 00 byte, 01 half, 10/11 word
- d_req, d_we, d_addr, d_wdata, d_load, d_store  in  as C  port D equivalents
- c_ack, d_ack  out  1 each  one-cycle completion pulse per port
- c_rdata, d_rdata  out  32 each  registered read data; held until that port's next ack
- c_stall  out  1  combinational: c_req & ~c_ack
- err  out  1  valid with an ack; the completed access was out of range
- busy  out  1  state != IDLE
- m_addr, m_din  out  32 each  memory address; memory write data
- m_load  out  3  memory load type
- m_store  out  2  memory store size
- m_rd, m_wr  out  1 each  memory read / write strobes
- m_dout  in  32  memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: sample requests. On a winner, latch its fields into the m_* registers and go to ISSUE. On an error, skip the memory and go to RESP.
  - ISSUE: m_rd or m_wr = 1 for exactly this cycle. Write → RESP; read → WAIT.
  - WAIT: m_rd = 0. Capture m_dout into the winner's rdata at the end of this cycle. → RESP.
  - RESP: the winner's ack = 1 and err is valid. All requests are ignored. → IDLE.
- Arbitration (IDLE only):
  - Only one requesting → that port wins.
  - Both requesting → C wins, unless starve_cnt == STARVE_LIMIT, in which case D wins.
  - starve_cnt increments on each C grant made while d_req = 1. It clears on a D grant or whenever d_req = 0 in IDLE. It saturates at STARVE_LIMIT.
- Access size:
  - Read: load 000/001 → 1 byte; 010/011 → 2; others → 4.
  - Write: store 00 → 1; 01 → 2; 10/11 → 4.
- Range check: err if addr > MEM_BYTES − size, computed in 33-bit unsigned arithmetic so addresses near 2^32 cannot wrap.
  - An erroring access issues no m_rd/m_wr.
  - For an erroring read, the port's rdata is set to 0.
  - The errored port still gets its ack.
- m_addr, m_din, m_load and m_store hold their latched values from ISSUE through RESP and are unchanged in IDLE. m_rd and m_wr are 0 outside ISSUE.
- Requester rule: hold req and all fields stable until ack. In the ack cycle, the requester may drop req or present the next request; the new request is sampled in the following IDLE cycle.
- Reset values: all outputs 0, state IDLE, starve_cnt 0, both rdata registers 0.
- Reset mid-operation: any state → IDLE at the next edge with no ack issued.
  - A write already strobed in ISSUE has already committed in memory; this is accepted.
  - A read that was in WAIT is discarded.

## Timing
- Request sampled at edge t (state IDLE before t).
- Write: ISSUE in cycle t..t+1, memory commits on the falling edge inside ISSUE, ack high in t+1..t+2.
- Read: ISSUE t..t+1, memory updates m_dout at t+1, WAIT captures it at t+2, ack and rdata valid in t+2..t+3.
- Error: state goes IDLE → RESP directly; ack high in t..t+1.
- Back-to-back throughput: a write takes 3 cycles per access, a read 4, including the IDLE sample cycle.
- c_stall is high from C request until its ack cycle, where it falls combinationally.

## Test plan
- C lw at 0x10 after D sw 0x11223344 at 0x10 → D ack 3 cycles after sample; C ack shows c_rdata 0x11223344, err 0.
- C sb 0x80 at 0x21, then C lb at 0x21 → 0xFFFFFF80; C lbu → 0x00000080; m_wr high exactly one cycle per write.
- c_req and d_req both held continuously with STARVE_LIMIT = 4 → grant order C,C,C,C,D,C,C,C,C,D; d_req dropped → counter clears.
- C lw at 1022 (MEM_BYTES 1024) → err = 1, c_rdata 0, no m_rd; D lw at 0xFFFFFFFE → err = 1, no wrap; sb at 1023 → err = 0.
- rst_n low during WAIT → state IDLE, no ack, m_rd/m_wr/busy 0, both rdata 0 the next cycle.
- Requester keeps req high through its ack cycle with new fields → exactly one new access starts from the following IDLE cycle; no duplicate access.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_if
//  Description : Bundle of the two requester ports (C = CPU MEM stage,
//                D = loader/debug) and the shared data-memory port seen by
//                the dmem_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if;
    // Port C request
    logic        c_req;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [2:0]  c_load;
    logic [1:0]  c_store;
    // Port D request
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_load;
    logic [1:0]  d_store;
    // Responses and status
    logic        c_ack;
    logic        d_ack;
    logic [31:0] c_rdata;
    logic [31:0] d_rdata;
    logic        c_stall;
    logic        err;
    logic        busy;
    // Memory side
    logic [31:0] m_addr;
    logic [31:0] m_din;
    logic [2:0]  m_load;
    logic [1:0]  m_store;
    logic        m_rd;
    logic        m_wr;
    logic [31:0] m_dout;

    // Arbiter view
    modport slave (
        input  c_req, c_we, c_addr, c_wdata, c_load, c_store,
        input  d_req, d_we, d_addr, d_wdata, d_load, d_store,
        input  m_dout,
        output c_ack, d_ack, c_rdata, d_rdata, c_stall, err, busy,
        output m_addr, m_din, m_load, m_store, m_rd, m_wr
    );

    // Environment view: requesters plus the memory
    modport master (
        output c_req, c_we, c_addr, c_wdata, c_load, c_store,
        output d_req, d_we, d_addr, d_wdata, d_load, d_store,
        output m_dout,
        input  c_ack, d_ack, c_rdata, d_rdata, c_stall, err, busy,
        input  m_addr, m_din, m_load, m_store, m_rd, m_wr
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-port arbiter/sequencer for the byte-addressed data
//                memory. Port C (CPU) normally wins; port D (loader/debug)
//                is forced through after STARVE_LIMIT consecutive C grants.
//                Out-of-range accesses are acknowledged with err and never
//                reach the memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int MEM_BYTES    = 1024,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int              CNT_W        = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [32:0]     C_MEM_BYTES  = 33'(MEM_BYTES);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_sel_d;      // current access belongs to port D
    logic             r_we;
    logic             r_err;
    logic [31:0]      r_m_addr;
    logic [31:0]      r_m_din;
    logic [2:0]       r_m_load;
    logic [1:0]       r_m_store;
    logic [31:0]      r_c_rdata;
    logic [31:0]      r_d_rdata;

    logic             w_grant;
    logic             w_grant_d;
    logic             w_sel_we;
    logic [31:0]      w_sel_addr;
    logic [31:0]      w_sel_wdata;
    logic [2:0]       w_sel_load;
    logic [1:0]       w_sel_store;
    logic [2:0]       w_size;
    logic             w_sel_err;

    // Arbitration, winner field mux, access size and 33-bit range check
    always_comb begin
        w_grant_d   = bus.d_req & (~bus.c_req | (r_starve_cnt == C_STARVE_MAX));
        w_grant     = (r_state == IDLE) & (bus.c_req | bus.d_req);
        w_sel_we    = w_grant_d ? bus.d_we    : bus.c_we;
        w_sel_addr  = w_grant_d ? bus.d_addr  : bus.c_addr;
        w_sel_wdata = w_grant_d ? bus.d_wdata : bus.c_wdata;
        w_sel_load  = w_grant_d ? bus.d_load  : bus.c_load;
        w_sel_store = w_grant_d ? bus.d_store : bus.c_store;
        w_size      = 3'd4;
        if (w_sel_we) begin
            if (w_sel_store == 2'd0)      w_size = 3'd1;
            else if (w_sel_store == 2'd1) w_size = 3'd2;
        end else begin
            if (w_sel_load <= 3'd1)       w_size = 3'd1;
            else if (w_sel_load <= 3'd3)  w_size = 3'd2;
        end
        // Zero-extended to 33 bits so an address near 2^32 cannot wrap past the limit
        w_sel_err   = ({1'b0, w_sel_addr} > (C_MEM_BYTES - {30'd0, w_size}));
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; an erroring access bypasses the memory entirely
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_state_nxt = w_sel_err ? RESP : ISSUE;
            ISSUE:   w_state_nxt = r_we ? RESP : WAIT;
            WAIT:    w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Starvation counter, grant latching and per-port read data capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
            r_sel_d      <= 1'b0;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_m_addr     <= '0;
            r_m_din      <= '0;
            r_m_load     <= '0;
            r_m_store    <= '0;
            r_c_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            if (r_state == IDLE) begin
                if (!bus.d_req)
                    r_starve_cnt <= '0;
                else if (w_grant_d)
                    r_starve_cnt <= '0;
                else if (w_grant && (r_starve_cnt != C_STARVE_MAX))
                    r_starve_cnt <= r_starve_cnt + CNT_W'(1);

                if (w_grant) begin
                    r_sel_d   <= w_grant_d;
                    r_we      <= w_sel_we;
                    r_err     <= w_sel_err;
                    r_m_addr  <= w_sel_addr;
                    r_m_din   <= w_sel_wdata;
                    r_m_load  <= w_sel_load;
                    r_m_store <= w_sel_store;
                    // A rejected read returns zero data
                    if (w_sel_err && !w_sel_we) begin
                        if (w_grant_d) r_d_rdata <= '0;
                        else           r_c_rdata <= '0;
                    end
                end
            end

            if (r_state == WAIT) begin
                if (r_sel_d) r_d_rdata <= bus.m_dout;
                else         r_c_rdata <= bus.m_dout;
            end
        end
    end

    assign bus.m_addr  = r_m_addr;
    assign bus.m_din   = r_m_din;
    assign bus.m_load  = r_m_load;
    assign bus.m_store = r_m_store;
    assign bus.m_rd    = (r_state == ISSUE) & ~r_we;
    assign bus.m_wr    = (r_state == ISSUE) &  r_we;
    assign bus.c_ack   = (r_state == RESP) & ~r_sel_d;
    assign bus.d_ack   = (r_state == RESP) &  r_sel_d;
    assign bus.err     = (r_state == RESP) &  r_err;
    assign bus.busy    = (r_state != IDLE);
    assign bus.c_rdata = r_c_rdata;
    assign bus.d_rdata = r_d_rdata;
    assign bus.c_stall = bus.c_req & ~bus.c_ack;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter with a byte memory
//                model and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
    localparam int MEM_BYTES    = 1024;
    localparam int STARVE_LIMIT = 4;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  load;
        logic [1:0]  store;
    } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_init = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if bus();

    dmem_arbiter #(
        .MEM_BYTES    (MEM_BYTES),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- memory environment ----------------
    logic [7:0] mem     [0:MEM_BYTES-1];
    logic [7:0] ref_mem [0:MEM_BYTES-1];
    logic [7:0] rb      [4];

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 5) & 255);
    endfunction

    // Writes commit on the falling edge inside the strobe cycle
    always @(negedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= init_byte(i);
        end else if (bus.m_wr) begin
            mem[10'(bus.m_addr)] <= bus.m_din[7:0];
            if (bus.m_store != 2'd0) mem[10'(bus.m_addr + 32'd1)] <= bus.m_din[15:8];
            if (bus.m_store[1]) begin
                mem[10'(bus.m_addr + 32'd2)] <= bus.m_din[23:16];
                mem[10'(bus.m_addr + 32'd3)] <= bus.m_din[31:24];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) rb[k] = mem[10'(bus.m_addr + 32'(k))];
    end

    // Registered read port with load extension
    always @(posedge clk) begin
        if (bus.m_rd) begin
            case (bus.m_load)
                3'd0:    bus.m_dout <= {{24{rb[0][7]}}, rb[0]};
                3'd1:    bus.m_dout <= {24'd0, rb[0]};
                3'd2:    bus.m_dout <= {{16{rb[1][7]}}, rb[1], rb[0]};
                3'd3:    bus.m_dout <= {16'd0, rb[1], rb[0]};
                default: bus.m_dout <= {rb[3], rb[2], rb[1], rb[0]};
            endcase
        end
    end

    // ---------------- reference model ----------------
    req_t        cq = '0;
    req_t        dq = '0;
    int          starve = 0;
    logic [31:0] exp_c_rdata = '0;
    logic [31:0] exp_d_rdata = '0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int acc_size(input req_t r);
        if (r.we) return (r.store == 2'd0) ? 1 : (r.store == 2'd1) ? 2 : 4;
        return (r.load <= 3'd1) ? 1 : (r.load <= 3'd3) ? 2 : 4;
    endfunction

    function automatic bit out_of_range(input req_t r);
        longint last;
        last = longint'({32'd0, r.addr}) + longint'(acc_size(r));
        return last > longint'(MEM_BYTES);
    endfunction

    function automatic logic [31:0] ref_read(input req_t r);
        longint v = 0;
        int     n = acc_size(r);
        for (int k = n - 1; k >= 0; k--) v = v * 256 + longint'(ref_mem[int'(r.addr) + k]);
        if ((r.load == 3'd0 || r.load == 3'd2) && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_write(input req_t r);
        for (int k = 0; k < acc_size(r); k++) ref_mem[int'(r.addr) + k] = r.wdata[8*k +: 8];
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.req   = 1'b1;
        r.we    = 1'($urandom_range(0, 1));
        r.wdata = $urandom;
        r.load  = 3'($urandom_range(0, 7));
        r.store = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 9))
            0:       r.addr = 32'(MEM_BYTES - 4) + 32'($urandom_range(0, 3));
            1:       r.addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            default: r.addr = 32'($urandom_range(0, 31));
        endcase
        return r;
    endfunction

    function automatic req_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] load, input logic [1:0] store);
        req_t r;
        r.req = 1'b1; r.we = we; r.addr = addr; r.wdata = wdata; r.load = load; r.store = store;
        return r;
    endfunction

    task automatic apply();
        bus.c_req = cq.req; bus.c_we = cq.we; bus.c_addr = cq.addr;
        bus.c_wdata = cq.wdata; bus.c_load = cq.load; bus.c_store = cq.store;
        bus.d_req = dq.req; bus.d_we = dq.we; bus.d_addr = dq.addr;
        bus.d_wdata = dq.wdata; bus.d_load = dq.load; bus.d_store = dq.store;
    endtask

    // One arbitration round, entered just after a rising edge with the DUT idle.
    // renew: what the winner presents in its ack cycle (0 drop, 1 new, 2 random).
    task automatic run_round(input int renew, output int win, output logic [31:0] rd, output logic e);
        bit   exp_d, exp_err, got;
        int   lat, n, nrd, nwr, mode;
        req_t w;
        logic [31:0] val;
        win = 0; rd = '0; e = 1'b0;
        apply();
        if (!cq.req && !dq.req) begin
            @(negedge clk);
            check("idle_busy", 32'(bus.busy), 32'd0);
            check("idle_ack", 32'({bus.c_ack, bus.d_ack}), 32'd0);
            starve = 0;
            @(posedge clk); #1;
            return;
        end
        exp_d = dq.req && (!cq.req || starve == STARVE_LIMIT);
        if (!dq.req || exp_d) starve = 0;
        else if (starve < STARVE_LIMIT) starve++;
        w       = exp_d ? dq : cq;
        exp_err = out_of_range(w);
        lat     = exp_err ? 2 : (w.we ? 3 : 4);
        n = 0; nrd = 0; nwr = 0; got = 0;
        while (!got && n < 12) begin
            @(negedge clk);
            n++;
            nrd += int'(bus.m_rd);
            nwr += int'(bus.m_wr);
            check("c_stall", 32'(bus.c_stall), 32'(cq.req && !(n == lat && !exp_d)));
            check("busy", 32'(bus.busy), 32'(n > 1));
            if (bus.c_ack || bus.d_ack) got = 1;
        end
        check("ack_latency", 32'(n), 32'(lat));
        check("ack_port", 32'({bus.c_ack, bus.d_ack}), exp_d ? 32'd1 : 32'd2);
        check("err", 32'(bus.err), 32'(exp_err));
        check("m_rd_count", 32'(nrd), 32'(!exp_err && !w.we));
        check("m_wr_count", 32'(nwr), 32'(!exp_err && w.we));
        if (!exp_err) check("m_addr", bus.m_addr, w.addr);
        if (!exp_err && w.we) ref_write(w);
        if (!w.we) begin
            val = exp_err ? 32'd0 : ref_read(w);
            if (exp_d) exp_d_rdata = val;
            else       exp_c_rdata = val;
        end
        check("c_rdata", bus.c_rdata, exp_c_rdata);
        check("d_rdata", bus.d_rdata, exp_d_rdata);
        win = bus.d_ack ? 2 : (bus.c_ack ? 1 : 0);
        rd  = bus.d_ack ? bus.d_rdata : bus.c_rdata;
        e   = bus.err;
        mode = (renew == 2) ? int'($urandom_range(0, 1)) : renew;
        if (exp_d) dq = (mode != 0) ? rand_req() : '0;
        else       cq = (mode != 0) ? rand_req() : '0;
        apply();
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    int          win;
    logic [31:0] rd;
    logic        e;
    int          exp_order [19] = '{1,1,1,1,2,1,1,1,1,2,1,1,1,1,1,1,1,1,2};

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(i);
        apply();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_acks", 32'({bus.c_ack, bus.d_ack, bus.err}), 32'd0);
        check("rst_strobes", 32'({bus.m_rd, bus.m_wr}), 32'd0);
        check("rst_c_rdata", bus.c_rdata, 32'd0);
        check("rst_d_rdata", bus.d_rdata, 32'd0);
        check("rst_m_addr", bus.m_addr, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_init = 1'b0;

        // D word store then C word load of the same location
        dq = mk(1'b1, 32'h10, 32'h1122_3344, 3'd0, 2'd2);
        run_round(0, win, rd, e);
        check("sw_winner", 32'(win), 32'd2);
        cq = mk(1'b0, 32'h10, 32'd0, 3'd4, 2'd0);
        run_round(0, win, rd, e);
        check("lw_data", rd, 32'h1122_3344);
        check("lw_err", 32'(e), 32'd0);

        // Byte store and signed/unsigned byte loads
        cq = mk(1'b1, 32'h21, 32'hABCD_EF80, 3'd0, 2'd0);
        run_round(0, win, rd, e);
        cq = mk(1'b0, 32'h21, 32'd0, 3'd0, 2'd0);
        run_round(0, win, rd, e);
        check("lb_data", rd, 32'hFFFF_FF80);
        cq = mk(1'b0, 32'h21, 32'd0, 3'd1, 2'd0);
        run_round(0, win, rd, e);
        check("lbu_data", rd, 32'h0000_0080);

        // Range boundaries
        cq = mk(1'b0, 32'd1022, 32'd0, 3'd4, 2'd0);
        run_round(0, win, rd, e);
        check("lw1022_err", 32'(e), 32'd1);
        check("lw1022_data", rd, 32'd0);
        dq = mk(1'b0, 32'hFFFF_FFFE, 32'd0, 3'd4, 2'd0);
        run_round(0, win, rd, e);
        check("lw_wrap_err", 32'(e), 32'd1);
        cq = mk(1'b1, 32'd1023, 32'h0000_005A, 3'd0, 2'd0);
        run_round(0, win, rd, e);
        check("sb1023_err", 32'(e), 32'd0);

        // Starvation ordering with both ports held; D dropped once at round 13
        for (int i = 0; i < 19; i++) begin
            if (!cq.req) cq = rand_req();
            if (i == 13)      dq = '0;
            else if (!dq.req) dq = rand_req();
            run_round(0, win, rd, e);
            check("grant_order", 32'(win), 32'(exp_order[i]));
        end

        // Randomized traffic on both ports
        for (int i = 0; i < 400; i++) begin
            if (!cq.req && $urandom_range(0, 3) != 0) cq = rand_req();
            if (!dq.req && $urandom_range(0, 3) != 0) dq = rand_req();
            run_round(2, win, rd, e);
        end

        // Reset while a read sits in WAIT
        cq = '0; dq = '0;
        run_round(0, win, rd, e);
        cq = mk(1'b0, 32'h10, 32'd0, 3'd4, 2'd0);
        apply();
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_m_rd", 32'(bus.m_rd), 32'd1);
        @(negedge clk);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        cq = '0;
        apply();
        @(negedge clk);
        check("wait_rst_busy", 32'(bus.busy), 32'd0);
        check("wait_rst_acks", 32'({bus.c_ack, bus.d_ack}), 32'd0);
        check("wait_rst_strobes", 32'({bus.m_rd, bus.m_wr}), 32'd0);
        check("wait_rst_c_rdata", bus.c_rdata, 32'd0);
        check("wait_rst_d_rdata", bus.d_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_acks", 32'({bus.c_ack, bus.d_ack}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
